// File: rtl/auth_resp_arbiter.sv
// auth_resp_arbiter: round-robin sharing of one authentication responder between N_REQ requesters, with a response watchdog
`ifndef MSG_LEN
`define MSG_LEN 32
`endif

module auth_resp_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*`MSG_LEN-1:0] req_msg,
    output logic [N_REQ-1:0]          req_grant,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ack,
    output logic [`MSG_LEN-1:0]       rsp_msg,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      resp_req_in,
    output logic [`MSG_LEN-1:0]       auth_msg_resp_in,
    output logic                      Ack_in,
    input  logic                      resp_req_out,
    input  logic [`MSG_LEN-1:0]       auth_msg_resp_out
);
    localparam int ML = `MSG_LEN;
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_RSP, ACK, DELIVER} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic [N_REQ-1:0] r_req_grant;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [ML-1:0]    r_rsp_msg;
    logic             r_rsp_timeout;
    logic             r_busy;
    logic             r_resp_req_in;
    logic [ML-1:0]    r_auth_msg;
    logic             r_ack_in;

    logic             w_any;
    logic [IW-1:0]    w_idx;
    logic             w_expired;
    logic [N_REQ-1:0] w_idx_onehot;

    assign w_expired    = (r_cnt == CW'(TIMEOUT - 1));
    assign w_idx_onehot = N_REQ'(1) << r_idx;

    // Round-robin search starting just after the last served requester; nearer candidates overwrite farther ones
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[(int'(r_last) + k) % N_REQ]) begin
                w_any = 1'b1;
                w_idx = IW'((int'(r_last) + k) % N_REQ);
            end
        end
    end

    // Transaction FSM: grant, wait for answer or watchdog, acknowledge, deliver
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_last        <= IW'(N_REQ - 1);
            r_idx         <= '0;
            r_cnt         <= '0;
            r_req_grant   <= '0;
            r_rsp_valid   <= '0;
            r_rsp_msg     <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_resp_req_in <= 1'b0;
            r_auth_msg    <= '0;
            r_ack_in      <= 1'b0;
        end else begin
            r_req_grant <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx         <= w_idx;
                        r_auth_msg    <= req_msg[w_idx*ML +: ML];
                        r_req_grant   <= N_REQ'(1) << w_idx;
                        r_resp_req_in <= 1'b1;
                        r_cnt         <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (resp_req_out) begin
                        r_rsp_msg     <= auth_msg_resp_out;
                        r_resp_req_in <= 1'b0;
                        r_ack_in      <= 1'b1;
                        r_state       <= ACK;
                    end else if (w_expired) begin
                        r_resp_req_in <= 1'b0;
                        r_rsp_msg     <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= w_idx_onehot;
                        r_state       <= DELIVER;
                    end
                end
                ACK: begin
                    if (!resp_req_out) begin
                        r_ack_in      <= 1'b0;
                        r_rsp_valid   <= w_idx_onehot;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (rsp_ack[r_idx]) begin
                        r_rsp_valid   <= '0;
                        r_rsp_msg     <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_last        <= r_idx;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_grant        = r_req_grant;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_msg          = r_rsp_msg;
    assign rsp_timeout      = r_rsp_timeout;
    assign busy             = r_busy;
    assign resp_req_in      = r_resp_req_in;
    assign auth_msg_resp_in = r_auth_msg;
    assign Ack_in           = r_ack_in;
endmodule

// File: tb/tb_auth_resp_arbiter.sv
// tb_auth_resp_arbiter: scenario tasks plus randomized transactions checked against a round-robin reference model
`ifndef MSG_LEN
`define MSG_LEN 32
`endif

module tb_auth_resp_arbiter;
    localparam int N  = 2;
    localparam int TO = 8;
    localparam int ML = `MSG_LEN;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*ML-1:0] req_msg = '0;
    logic [N-1:0]    req_grant;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ack = '0;
    logic [ML-1:0]   rsp_msg;
    logic            rsp_timeout;
    logic            busy;
    logic            resp_req_in;
    logic [ML-1:0]   auth_msg_resp_in;
    logic            Ack_in;
    logic            resp_req_out = 1'b0;
    logic [ML-1:0]   auth_msg_resp_out = '0;

    int n_pass = 0;
    int n_total = 0;
    int m_last = N - 1;

    auth_resp_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_msg(req_msg),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_msg(rsp_msg), .rsp_timeout(rsp_timeout), .busy(busy),
        .resp_req_in(resp_req_in), .auth_msg_resp_in(auth_msg_resp_in),
        .Ack_in(Ack_in), .resp_req_out(resp_req_out),
        .auth_msg_resp_out(auth_msg_resp_out)
    );

    always #5 clk = ~clk;

    // Reference arbitration: first pending requester after the last served one, wrapping around
    function automatic int rr_pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        req_valid = '0; rsp_ack = '0; resp_req_out = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_last = N - 1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick;
        n_total++; if ({req_grant, rsp_valid, rsp_timeout, busy, resp_req_in, Ack_in} !== '0) $display("FAIL reset_ctrl got %b exp 0", {req_grant, rsp_valid, rsp_timeout, busy, resp_req_in, Ack_in}); else n_pass++;
        n_total++; if ({rsp_msg, auth_msg_resp_in} !== '0) $display("FAIL reset_data got %h exp 0", {rsp_msg, auth_msg_resp_in}); else n_pass++;
        reset = 1'b1;
        m_last = N - 1;
        tick;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_single;
        logic [ML-1:0] m, a;
        m = 32'h0181_A5C3; a = 32'h0102_0304;
        req_valid = 2'b01; req_msg = {32'h0, m};
        tick;
        n_total++; if (req_grant !== 2'b01) $display("FAIL single_grant got %b exp 01", req_grant); else n_pass++;
        n_total++; if (resp_req_in !== 1'b1 || busy !== 1'b1) $display("FAIL single_req got %b%b exp 11", resp_req_in, busy); else n_pass++;
        n_total++; if (auth_msg_resp_in !== m) $display("FAIL single_msg_in got %h exp %h", auth_msg_resp_in, m); else n_pass++;
        req_valid = 2'b00;
        tick;
        n_total++; if (req_grant !== 2'b00) $display("FAIL single_grant_pulse got %b exp 00", req_grant); else n_pass++;
        repeat (3) tick;
        resp_req_out = 1'b1; auth_msg_resp_out = a;
        tick;
        n_total++; if (Ack_in !== 1'b1 || resp_req_in !== 1'b0) $display("FAIL single_ack got ack=%b req=%b exp ack=1 req=0", Ack_in, resp_req_in); else n_pass++;
        repeat (2) tick;
        n_total++; if (Ack_in !== 1'b1 || rsp_valid !== 2'b00) $display("FAIL single_ack_hold got ack=%b valid=%b exp 1 00", Ack_in, rsp_valid); else n_pass++;
        resp_req_out = 1'b0;
        tick;
        n_total++; if (Ack_in !== 1'b0) $display("FAIL single_ack_drop got %b exp 0", Ack_in); else n_pass++;
        n_total++; if (rsp_valid !== 2'b01 || rsp_msg !== a || rsp_timeout !== 1'b0) $display("FAIL single_rsp got %b %h %b exp 01 %h 0", rsp_valid, rsp_msg, rsp_timeout, a); else n_pass++;
        tick;
        n_total++; if (rsp_valid !== 2'b01 || rsp_msg !== a) $display("FAIL single_rsp_hold got %b %h exp 01 %h", rsp_valid, rsp_msg, a); else n_pass++;
        rsp_ack = 2'b01;
        tick;
        rsp_ack = 2'b00;
        m_last = 0;
        n_total++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_msg !== '0) $display("FAIL single_done got %b %b %h exp 00 0 0", rsp_valid, busy, rsp_msg); else n_pass++;
    endtask

    task automatic test_round_robin;
        int order [4];
        int p;
        apply_reset;
        req_valid = 2'b11; req_msg = {32'h1111_1111, 32'h0000_0000};
        for (int n = 0; n < 4; n++) begin
            p = rr_pick(req_valid);
            tick;
            order[n] = (req_grant == 2'b10) ? 1 : (req_grant == 2'b01) ? 0 : -1;
            n_total++; if (req_grant !== (2'b01 << p)) $display("FAIL rr_grant%0d got %b exp %b", n, req_grant, 2'b01 << p); else n_pass++;
            resp_req_out = 1'b1; auth_msg_resp_out = 32'(n);
            tick;
            resp_req_out = 1'b0;
            tick;
            rsp_ack = 2'b01 << p;
            tick;
            rsp_ack = 2'b00;
            m_last = p;
        end
        n_total++; if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) $display("FAIL rr_order got %0d%0d%0d%0d exp 0101", order[0], order[1], order[2], order[3]); else n_pass++;
        req_valid = 2'b00;
    endtask

    task automatic test_timeout;
        int cnt;
        bit ack_seen;
        int p;
        req_valid = 2'b01; req_msg = {32'h0, 32'hDEAD_BEEF};
        p = rr_pick(req_valid);
        tick;
        req_valid = 2'b00;
        cnt = 0; ack_seen = 0;
        for (int i = 0; i < 40 && resp_req_in === 1'b1; i++) begin
            cnt++;
            if (Ack_in) ack_seen = 1;
            tick;
        end
        n_total++; if (cnt != TO) $display("FAIL timeout_len got %0d exp %0d", cnt, TO); else n_pass++;
        n_total++; if (rsp_valid !== (2'b01 << p) || rsp_timeout !== 1'b1 || rsp_msg !== '0) $display("FAIL timeout_rsp got %b %b %h exp %b 1 0", rsp_valid, rsp_timeout, rsp_msg, 2'b01 << p); else n_pass++;
        n_total++; if (ack_seen || Ack_in !== 1'b0) $display("FAIL timeout_noack got %b exp 0", ack_seen | Ack_in); else n_pass++;
        rsp_ack = 2'b01 << p;
        tick;
        rsp_ack = 2'b00;
        m_last = p;
        n_total++; if (busy !== 1'b0 || rsp_timeout !== 1'b0) $display("FAIL timeout_done got %b%b exp 00", busy, rsp_timeout); else n_pass++;
    endtask

    task automatic test_simultaneous;
        int p;
        req_valid = 2'b11; req_msg = {32'hCAFE_0001, 32'hCAFE_0000};
        p = rr_pick(req_valid);
        tick;
        req_valid = 2'b00;
        repeat (TO - 1) tick;
        n_total++; if (resp_req_in !== 1'b1) $display("FAIL simul_pre got %b exp 1", resp_req_in); else n_pass++;
        resp_req_out = 1'b1; auth_msg_resp_out = 32'h5A5A_1234;
        tick;
        n_total++; if (Ack_in !== 1'b1 || rsp_valid !== 2'b00 || rsp_timeout !== 1'b0) $display("FAIL simul_ack got %b %b %b exp 1 00 0", Ack_in, rsp_valid, rsp_timeout); else n_pass++;
        resp_req_out = 1'b0;
        tick;
        n_total++; if (rsp_valid !== (2'b01 << p) || rsp_msg !== 32'h5A5A_1234 || rsp_timeout !== 1'b0) $display("FAIL simul_rsp got %b %h %b exp %b 5a5a1234 0", rsp_valid, rsp_msg, rsp_timeout, 2'b01 << p); else n_pass++;
        rsp_ack = 2'b01 << p;
        tick;
        rsp_ack = 2'b00;
        m_last = p;
    endtask

    task automatic test_wrong_ack;
        req_valid = 2'b10; req_msg = {32'h7777_0001, 32'h0};
        tick;
        n_total++; if (req_grant !== 2'b10) $display("FAIL wack_grant got %b exp 10", req_grant); else n_pass++;
        req_valid = 2'b00;
        resp_req_out = 1'b1; auth_msg_resp_out = 32'h0BAD_F00D;
        tick;
        resp_req_out = 1'b0;
        tick;
        rsp_ack = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_total++; if (rsp_valid !== 2'b10 || busy !== 1'b1 || rsp_msg !== 32'h0BAD_F00D) $display("FAIL wack_hold%0d got %b %b %h exp 10 1 0badf00d", i, rsp_valid, busy, rsp_msg); else n_pass++;
        end
        rsp_ack = 2'b10;
        tick;
        rsp_ack = 2'b00;
        m_last = 1;
        n_total++; if (rsp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL wack_done got %b %b exp 00 0", rsp_valid, busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        req_valid = 2'b01; req_msg = {32'h0, 32'h1357_9BDF};
        tick;
        req_valid = 2'b00;
        repeat (2) tick;
        #2;
        reset = 1'b0;
        #1;
        n_total++; if ({req_grant, rsp_valid, rsp_timeout, busy, resp_req_in, Ack_in} !== '0 || auth_msg_resp_in !== '0) $display("FAIL rstmid_async got %b %h exp 0", {req_grant, rsp_valid, rsp_timeout, busy, resp_req_in, Ack_in}, auth_msg_resp_in); else n_pass++;
        #1;
        reset = 1'b1;
        m_last = N - 1;
        req_valid = 2'b11; req_msg = {32'h2222_2222, 32'h1111_1111};
        tick;
        n_total++; if (req_grant !== 2'b01 || auth_msg_resp_in !== 32'h1111_1111) $display("FAIL rstmid_regrant got %b %h exp 01 11111111", req_grant, auth_msg_resp_in); else n_pass++;
        req_valid = 2'b00;
        resp_req_out = 1'b1;
        tick;
        resp_req_out = 1'b0;
        tick;
        rsp_ack = 2'b01;
        tick;
        rsp_ack = 2'b00;
        m_last = 0;
    endtask

    task automatic test_random;
        logic [N-1:0]  p, eg;
        logic [ML-1:0] m0, m1, ans;
        int pk, d, h, w;
        p = '0;
        for (int n = 0; n < 40; n++) begin
            p = p | N'($urandom_range(0, 3));
            if (p == '0) p = N'($urandom_range(1, 3));
            m0 = $urandom; m1 = $urandom;
            req_valid = p; req_msg = {m1, m0};
            pk = rr_pick(p);
            eg = N'(1) << pk;
            tick;
            n_total++; if (req_grant !== eg) $display("FAIL rand%0d_grant got %b exp %b", n, req_grant, eg); else n_pass++;
            n_total++; if (auth_msg_resp_in !== (pk == 1 ? m1 : m0)) $display("FAIL rand%0d_msg_in got %h exp %h", n, auth_msg_resp_in, pk == 1 ? m1 : m0); else n_pass++;
            p[pk] = 1'b0;
            req_valid = p;
            d = $urandom_range(0, 10);
            if (d >= TO) begin
                repeat (TO) tick;
                n_total++; if (rsp_valid !== eg || rsp_timeout !== 1'b1 || rsp_msg !== '0 || resp_req_in !== 1'b0) $display("FAIL rand%0d_to got %b %b %h %b exp %b 1 0 0", n, rsp_valid, rsp_timeout, rsp_msg, resp_req_in, eg); else n_pass++;
            end else begin
                repeat (d) tick;
                ans = $urandom;
                resp_req_out = 1'b1; auth_msg_resp_out = ans;
                tick;
                n_total++; if (Ack_in !== 1'b1 || resp_req_in !== 1'b0) $display("FAIL rand%0d_ack got %b %b exp 1 0", n, Ack_in, resp_req_in); else n_pass++;
                h = $urandom_range(0, 2);
                repeat (h) tick;
                resp_req_out = 1'b0;
                tick;
                n_total++; if (rsp_valid !== eg || rsp_msg !== ans || rsp_timeout !== 1'b0 || Ack_in !== 1'b0) $display("FAIL rand%0d_rsp got %b %h %b %b exp %b %h 0 0", n, rsp_valid, rsp_msg, rsp_timeout, Ack_in, eg, ans); else n_pass++;
            end
            w = $urandom_range(0, 2);
            rsp_ack = ~eg;
            repeat (w) tick;
            n_total++; if (rsp_valid !== eg || busy !== 1'b1) $display("FAIL rand%0d_hold got %b %b exp %b 1", n, rsp_valid, busy, eg); else n_pass++;
            rsp_ack = eg;
            tick;
            rsp_ack = '0;
            m_last = pk;
            n_total++; if (rsp_valid !== '0 || busy !== 1'b0 || rsp_timeout !== 1'b0) $display("FAIL rand%0d_done got %b %b %b exp 0 0 0", n, rsp_valid, busy, rsp_timeout); else n_pass++;
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_simultaneous;
        test_wrong_ack;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
